// File: rtl/mccontrol.sv
// mccontrol: multicycle control FSM for the 16-bit, 4-bit-opcode CPU.
// Optional MCCONTROL_PERFCNT_EN adds the instret/cycles performance counters.
module mccontrol #(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [3:0]   op,
  input  logic         zero,
  input  logic         lt,
  input  logic         mem_ready,
  input  logic         mul_done,
  output logic         mem_req,
  output logic         memread,
  output logic         memwrite,
  output logic         iord,
  output logic         irwrite,
  output logic         pcwrite,
  output logic         regwrite,
  output logic         regdst,
  output logic         hilo_write,
  output logic         mul_start,
  output logic         alusrc_a,
  output logic [1:0]   alusrc_b,
  output logic [1:0]   pcsrc,
  output logic [1:0]   wbsel,
  output logic [3:0]   aluop,
  output logic [3:0]   state,
  output logic [n-1:0] instret,
  output logic [n-1:0] cycles
);
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC     = 4'd3,
    ALUWB    = 4'd4,
    MEMADDR  = 4'd5,
    MEMRD    = 4'd6,
    MEMWB    = 4'd7,
    MEMWR    = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    MULSTART = 4'd11,
    MULWAIT  = 4'd12,
    HILOWB   = 4'd13
  } state_t;

  localparam logic [3:0] OP_NOOP = 4'h0;
  localparam logic [3:0] OP_JR   = 4'h1;
  localparam logic [3:0] OP_JI   = 4'h2;
  localparam logic [3:0] OP_BE   = 4'h3;
  localparam logic [3:0] OP_BL   = 4'h4;
  localparam logic [3:0] OP_MFHI = 4'h5;
  localparam logic [3:0] OP_MFLO = 4'h6;
  localparam logic [3:0] OP_LW   = 4'h7;
  localparam logic [3:0] OP_SW   = 4'h8;
  localparam logic [3:0] OP_MULT = 4'hd;

  state_t     st, nxt;
  logic [3:0] op_q;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st   <= IDLE;
      op_q <= '0;
    end else begin
      st   <= nxt;
      op_q <= (st == DECODE) ? op : op_q;
    end

  always_comb begin
    nxt = st;
    case (st)
      IDLE:     nxt = FETCH;
      FETCH:    nxt = mem_ready ? DECODE : FETCH;
      DECODE:
        case (op)
          OP_NOOP:         nxt = FETCH;
          OP_JR, OP_JI:    nxt = JUMP;
          OP_BE, OP_BL:    nxt = BRANCH;
          OP_MFHI, OP_MFLO: nxt = HILOWB;
          OP_LW, OP_SW:    nxt = MEMADDR;
          OP_MULT:         nxt = MULSTART;
          default:         nxt = EXEC;
        endcase
      EXEC:     nxt = ALUWB;
      ALUWB:    nxt = FETCH;
      MEMADDR:  nxt = (op_q == OP_LW) ? MEMRD : MEMWR;
      MEMRD:    nxt = mem_ready ? MEMWB : MEMRD;
      MEMWB:    nxt = FETCH;
      MEMWR:    nxt = mem_ready ? FETCH : MEMWR;
      BRANCH:   nxt = FETCH;
      JUMP:     nxt = FETCH;
      HILOWB:   nxt = FETCH;
      MULSTART: nxt = MULWAIT;
      MULWAIT:  nxt = mul_done ? FETCH : MULWAIT;
      default:  nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    hilo_write = 1'b0;
    mul_start  = 1'b0;
    alusrc_a   = 1'b0;
    alusrc_b   = 2'b00;
    pcsrc      = 2'b00;
    wbsel      = 2'b00;
    aluop      = 4'b1001;
    case (st)
      FETCH: begin
        mem_req  = 1'b1;
        memread  = 1'b1;
        alusrc_b = 2'b01;
        irwrite  = mem_ready;
        pcwrite  = mem_ready;
      end
      DECODE:   alusrc_b = 2'b10;
      EXEC: begin
        alusrc_a = 1'b1;
        aluop    = op_q;
      end
      ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      MEMADDR: begin
        alusrc_a = 1'b1;
        alusrc_b = 2'b10;
      end
      MEMRD: begin
        mem_req = 1'b1;
        memread = 1'b1;
        iord    = 1'b1;
      end
      MEMWB: begin
        regwrite = 1'b1;
        wbsel    = 2'b01;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      BRANCH: begin
        alusrc_a = 1'b1;
        aluop    = 4'b0011;
        pcsrc    = 2'b01;
        pcwrite  = (op_q == OP_BE && zero) || (op_q == OP_BL && lt);
      end
      JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = (op_q == OP_JR) ? 2'b11 : 2'b10;
      end
      HILOWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        wbsel    = (op_q == OP_MFHI) ? 2'b10 : 2'b11;
      end
      MULSTART: mul_start = 1'b1;
      MULWAIT:  hilo_write = mul_done;
      default: ;
    endcase
  end

  assign state = st;

`ifdef MCCONTROL_PERFCNT_EN
  // an instruction retires on every return to FETCH except the initial one out of IDLE
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cycles  <= '0;
      instret <= '0;
    end else begin
      cycles  <= (st != IDLE) ? cycles + 1'b1 : cycles;
      instret <= (nxt == FETCH && st != IDLE && st != FETCH) ? instret + 1'b1 : instret;
    end
`else
  assign cycles  = '0;
  assign instret = '0;
`endif
endmodule
